// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Optional feature macro: LONG_PRESS_EN (enables the long-press strobe in debounce_channel).
package button_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // released and stable
    P_WAIT = 2'd1,  // pressed level seen, waiting for it to stay stable
    HELD   = 2'd2,  // accepted press
    R_WAIT = 2'd3   // released level seen, waiting for it to stay stable
  } db_state_t;

  // 10 ms at 12 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd120000;
  // 1 s at 12 MHz
  localparam int unsigned LONG_CYCLES_DEF     = 32'd12000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter must be able to hold max(debounce, long) so the long count can saturate at LONG_CYCLES
  function automatic int unsigned cnt_width(input int unsigned db_cycles, input int unsigned long_cycles);
    return $clog2(max_u(db_cycles, long_cycles) + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser on the raw active-low pin, then a
// debounce FSM that accepts a level only after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles, emitting one-cycle press/release strobes.
// Optional feature macro: LONG_PRESS_EN -- when defined, the counter keeps
// running while HELD and fires a single long_press_o strobe after LONG_CYCLES.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,      // raw pin, active-low, asynchronous
  output logic level_o,       // debounced level, 1 = pressed
  output logic press_o,       // one-cycle strobe on accepted press
  output logic release_o,     // one-cycle strobe on accepted release
  output logic long_press_o   // one-cycle strobe on long hold
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);

  // The FSM spends one cycle in IDLE/HELD noticing the new level before the
  // wait state starts counting, so the wait state terminates when the counter
  // sits at DEBOUNCE_CYCLES-2. A 1-cycle debounce skips the wait states.
  localparam bit DB_SINGLE = (DEBOUNCE_CYCLES <= 1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

`ifdef LONG_PRESS_EN
  // Long strobe fires on the edge where the count has reached LONG_CYCLES-1;
  // the counter then parks at LONG_CYCLES so the strobe cannot repeat.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`endif

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;

  // Two-flop synchroniser; reset value 1 means "released" for an active-low pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // Debounce FSM with counter and registered level/strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      // strobes default low; each is raised for exactly one cycle below
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            cnt_q <= '0;
            if (DB_SINGLE) begin
              state_q <= HELD;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              state_q <= P_WAIT;
            end
          end
        end

        P_WAIT: begin
          if (!pressed) begin
            // bounce: drop back silently
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            level_q <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        HELD: begin
          if (!pressed) begin
            cnt_q <= '0;
            if (DB_SINGLE) begin
              state_q   <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              state_q <= R_WAIT;
            end
          end
`ifdef LONG_PRESS_EN
          else if (cnt_q == LONG_LAST) begin
            long_q <= 1'b1;
            cnt_q  <= LONG_SAT;
          end else if (cnt_q != LONG_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end

        R_WAIT: begin
          if (pressed) begin
            // bounce while releasing: still held, long count starts over
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: N_BUTTONS independent debounce channels, each turning
// a raw active-low asynchronous pin into a clean active-high level plus
// one-cycle press/release (and optionally long-press) strobes.
// Optional feature macro: LONG_PRESS_EN (long_press_o stays 0 when undefined).
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons_i,
  output logic [N_BUTTONS-1:0] level_o,
  output logic [N_BUTTONS-1:0] press_o,
  output logic [N_BUTTONS-1:0] release_o,
  output logic [N_BUTTONS-1:0] long_press_o
);

  // One fully independent channel per pin
  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .button_i     (buttons_i[gi]),
      .level_o      (level_o[gi]),
      .press_o      (press_o[gi]),
      .release_o    (release_o[gi]),
      .long_press_o (long_press_o[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with N_BUTTONS=2, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=10. Long-press expectations follow LONG_PRESS_EN.
module tb_button_debounce;

  localparam int unsigned NB = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned LC = 10;
`ifdef LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] buttons = 2'b00;
  logic [NB-1:0] level;
  logic [NB-1:0] press;
  logic [NB-1:0] rel;
  logic [NB-1:0] lng;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  button_debounce #(
    .N_BUTTONS       (NB),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buttons_i    (buttons),
    .level_o      (level),
    .press_o      (press),
    .release_o    (rel),
    .long_press_o (lng)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] pr,
                         input logic [1:0] rl, input logic [1:0] lg);
    chk({tag, "/level"},   level, lvl);
    chk({tag, "/press"},   press, pr);
    chk({tag, "/release"}, rel,   rl);
    chk({tag, "/long"},    lng,   lg);
  endtask

  // n cycles with no strobes and a constant level
  task automatic quiet(input int n, input logic [1:0] lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_all(tag, lvl, 2'b00, 2'b00, 2'b00);
    end
  endtask

  // one cycle on which the given strobes must appear
  task automatic event_at(input string tag, input logic [1:0] lvl, input logic [1:0] pr,
                          input logic [1:0] rl, input logic [1:0] lg);
    tick();
    chk_all(tag, lvl, pr, rl, lg);
  endtask

  initial begin
    // reset held with both pins pressed
    #1;
    chk_all("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    quiet(3, 2'b00, "rst_hold");
    rst = 1'b0;
    quiet(5, 2'b00, "rst_exit_wait");
    event_at("rst_exit_press", 2'b11, 2'b11, 2'b00, 2'b00);
    $display("txn: pressed-through-reset, press on both channels after 6 cycles");
    buttons = 2'b11;
    quiet(5, 2'b11, "rst_exit_rel_wait");
    event_at("rst_exit_release", 2'b00, 2'b00, 2'b11, 2'b00);
    $display("txn: both released, release strobes after 6 cycles");

    // clean press / release on channel 0
    buttons = 2'b10;
    quiet(5, 2'b00, "ch0_press_wait");
    event_at("ch0_press", 2'b01, 2'b01, 2'b00, 2'b00);
    buttons = 2'b11;
    quiet(5, 2'b01, "ch0_rel_wait");
    event_at("ch0_release", 2'b00, 2'b00, 2'b01, 2'b00);
    $display("txn: channel 0 clean press and release");

    // 3-cycle bounce on channel 0: nothing accepted
    buttons = 2'b10;
    quiet(3, 2'b00, "ch0_bounce_low");
    buttons = 2'b11;
    quiet(8, 2'b00, "ch0_bounce_after");
    $display("txn: channel 0 three-cycle bounce ignored");

    // channel 1 held 20 cycles: one press, one long strobe 10 cycles later
    buttons = 2'b01;
    quiet(5, 2'b00, "ch1_press_wait");
    event_at("ch1_press", 2'b10, 2'b10, 2'b00, 2'b00);
    quiet(9, 2'b10, "ch1_long_wait");
    event_at("ch1_long", 2'b10, 2'b00, 2'b00, LP_EN ? 2'b10 : 2'b00);
    quiet(4, 2'b10, "ch1_no_repeat");
    buttons = 2'b11;
    quiet(5, 2'b10, "ch1_rel_wait");
    event_at("ch1_release", 2'b00, 2'b00, 2'b10, 2'b00);
    $display("txn: channel 1 long hold, single long strobe, release");

    // simultaneous press, then a 2-cycle release bounce
    buttons = 2'b00;
    quiet(5, 2'b00, "both_press_wait");
    event_at("both_press", 2'b11, 2'b11, 2'b00, 2'b00);
    quiet(2, 2'b11, "both_hold");
    buttons = 2'b11;
    quiet(2, 2'b11, "both_rel_bounce");
    buttons = 2'b00;
    quiet(8, 2'b11, "both_after_bounce");
    quiet(4, 2'b11, "both_long_restart");
    event_at("both_long", 2'b11, 2'b00, 2'b00, LP_EN ? 2'b11 : 2'b00);
    buttons = 2'b11;
    quiet(5, 2'b11, "both_rel_wait");
    event_at("both_release", 2'b00, 2'b00, 2'b11, 2'b00);
    $display("txn: simultaneous press, release bounce ignored, long count restarted");

    // reset while channel 1 is HELD and channel 0 is in P_WAIT with cnt=2
    buttons = 2'b01;
    quiet(5, 2'b00, "mid_ch1_wait");
    event_at("mid_ch1_press", 2'b10, 2'b10, 2'b00, 2'b00);
    buttons = 2'b00;
    quiet(5, 2'b10, "mid_ch0_pwait");
    rst = 1'b1;
    #1;
    chk_all("mid_rst_assert", 2'b00, 2'b00, 2'b00, 2'b00);
    quiet(3, 2'b00, "mid_rst_hold");
    rst = 1'b0;
    quiet(5, 2'b00, "mid_fresh_wait");
    event_at("mid_fresh_press", 2'b11, 2'b11, 2'b00, 2'b00);
    buttons = 2'b11;
    quiet(5, 2'b11, "mid_rel_wait");
    event_at("mid_release", 2'b00, 2'b00, 2'b11, 2'b00);
    $display("txn: reset mid-debounce discarded state, re-press accepted fresh");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
